// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product sequencer and its MAC.
// The saturation limits are used only when DOT_SAT_EN is defined.
package mac_pkg;

    localparam int ACC_W = 26;
    localparam int OP_W  = 8;

    // Signed 16-bit clamp limits, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd32768;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CAPT  = 3'd4
    } dot_state_t;

endpackage : mac_pkg

// File: rtl/mac.sv
// Signed 8x8 -> 26-bit multiply-accumulate. The accumulator adds a*b on
// every clock edge, so callers gate the operands to zero when idle.
// clr_n is a synchronous clear that takes priority over accumulation.
module mac
    import mac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_n,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*OP_W-1:0] prod;

    assign prod = a * b;

    // Accumulate the sign-extended product; clear on reset or clr_n.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the values from before the edge, independent of ordering.
        if (!rst_n) begin
            acc <= '0;
        end else if (!clr_n) begin
            acc <= '0;
        end else begin
            acc <= acc + {{(ACC_W-2*OP_W){prod[2*OP_W-1]}}, prod};
        end
    end

endmodule : mac

// File: rtl/dot_ctrl.sv
// Dot-product sequencer: reads len operand pairs from two synchronous-read
// memories, feeds them to a mac instance and captures the sum.
// Optional macro DOT_SAT_EN clamps the captured result to signed 16 bits
// and reports clamping on sat; without it sat is tied low.
module dot_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W  = 7,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        len,
    input  logic [ADDR_W-1:0]       base_a,
    input  logic [ADDR_W-1:0]       base_b,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       addr_a,
    output logic [ADDR_W-1:0]       addr_b,
    input  logic signed [OP_W-1:0]  rdata_a,
    input  logic signed [OP_W-1:0]  rdata_b,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] result,
    output logic                    sat
);

    dot_state_t               state;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         idx;
    logic                     data_vld;
    logic                     clr_n;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  cap_val;
`ifdef DOT_SAT_EN
    logic                     cap_sat;
`endif

    // Zero the MAC operands whenever no read data is returning.
    always_comb begin
        op_a = data_vld ? rdata_a : '0;
        op_b = data_vld ? rdata_b : '0;
    end

    // Value (and clamp flag) to be loaded into result at capture.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cap_val = acc;
`ifdef DOT_SAT_EN
        cap_sat = 1'b0;
        if (acc > SAT_MAX) begin
            cap_val = SAT_MAX;
            cap_sat = 1'b1;
        end else if (acc < SAT_MIN) begin
            cap_val = SAT_MIN;
            cap_sat = 1'b1;
        end
`endif
    end

    // Job FSM with registered read strobe, addresses, MAC clear and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            idx      <= '0;
            data_vld <= 1'b0;
            clr_n    <= 1'b1;
            rd_en    <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef DOT_SAT_EN
            sat      <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            data_vld <= rd_en;
            if (abort && state != ST_IDLE) begin
                // Cancel: drop in-flight reads, keep result and sat.
                state    <= ST_IDLE;
                rd_en    <= 1'b0;
                data_vld <= 1'b0;
                clr_n    <= 1'b1;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state  <= ST_CLR;
                            len_q  <= len;
                            idx    <= '0;
                            clr_n  <= 1'b0;
                            busy   <= 1'b1;
                            rd_en  <= (len != '0);
                            addr_a <= base_a;
                            addr_b <= base_b;
                        end
                    end
                    ST_CLR: begin
                        clr_n <= 1'b1;
                        if (len_q == '0) begin
                            state <= ST_CAPT;
                            rd_en <= 1'b0;
                        end else if (len_q > LEN_W'(1)) begin
                            state  <= ST_RUN;
                            idx    <= idx + LEN_W'(1);
                            addr_a <= addr_a + ADDR_W'(1);
                            addr_b <= addr_b + ADDR_W'(1);
                        end else begin
                            state <= ST_DRAIN;
                            rd_en <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (idx == len_q - LEN_W'(1)) begin
                            state <= ST_DRAIN;
                            rd_en <= 1'b0;
                        end else begin
                            idx    <= idx + LEN_W'(1);
                            addr_a <= addr_a + ADDR_W'(1);
                            addr_b <= addr_b + ADDR_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        state <= ST_CAPT;
                    end
                    ST_CAPT: begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= cap_val;
`ifdef DOT_SAT_EN
                        sat    <= cap_sat;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef DOT_SAT_EN
    assign sat = 1'b0;
`endif

    mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .a     (op_a),
        .b     (op_b),
        .acc   (acc)
    );

endmodule : dot_ctrl

// File: tb/tb_dot_ctrl.sv
// Directed self-checking bench for dot_ctrl with behavioural
// synchronous-read operand memories.
module tb_dot_ctrl;

    localparam int LEN_W  = 7;
    localparam int ADDR_W = 8;

`ifdef DOT_SAT_EN
    localparam int   BIG_RES = 32767;
    localparam logic BIG_SAT = 1'b1;
`else
    localparam int   BIG_RES = 64516;
    localparam logic BIG_SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [LEN_W-1:0]    len;
    logic [ADDR_W-1:0]   base_a;
    logic [ADDR_W-1:0]   base_b;
    logic                rd_en;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic signed [7:0]   rdata_a;
    logic signed [7:0]   rdata_b;
    logic                busy;
    logic                done;
    logic signed [25:0]  result;
    logic                sat;

    logic signed [7:0]   mem_a [256];
    logic signed [7:0]   mem_b [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dot_ctrl #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .base_a  (base_a),
        .base_b  (base_b),
        .rd_en   (rd_en),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .sat     (sat)
    );

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rdata_a <= mem_a[addr_a];
            rdata_b <= mem_b[addr_b];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a job in the current cycle (cycle 0) and checks cycles
    // 1..l+3; returns positioned in the done cycle.
    task automatic run_job(input int l, input logic [7:0] ba,
                           input logic [7:0] bb, input int exp_res,
                           input logic exp_sat, input bit extra_start);
        logic [7:0] ea;
        logic [7:0] eb;
        start  = 1'b1;
        len    = LEN_W'(l);
        base_a = ba;
        base_b = bb;
        tick();
        start = extra_start;
        if (extra_start) begin
            len    = LEN_W'(5);
            base_a = 8'h00;
            base_b = 8'h00;
        end
        for (int c = 1; c <= l + 3; c++) begin
            if (c == l + 3) start = 1'b0;
            check($sformatf("busy_c%0d", c), busy, (c <= l + 2));
            check($sformatf("done_c%0d", c), done, (c == l + 3));
            check($sformatf("rd_en_c%0d", c), rd_en, (c <= l));
            if (c <= l) begin
                ea = ba + 8'(c - 1);
                eb = bb + 8'(c - 1);
                check($sformatf("addr_a_c%0d", c), addr_a, ea);
                check($sformatf("addr_b_c%0d", c), addr_b, eb);
            end
            if (c == l + 3) begin
                check("result", result, exp_res);
                check("sat", sat, exp_sat);
            end else begin
                tick();
            end
        end
        if (extra_start) begin
            tick();
            check("ignored_start_busy", busy, 1'b0);
            check("ignored_start_rd_en", rd_en, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h20] = 8'sd2;    mem_b[8'h30] = 8'sd3;
        mem_a[8'h10] = 8'sd1;    mem_b[8'h18] = 8'sd5;
        mem_a[8'h11] = 8'sd2;    mem_b[8'h19] = 8'sd6;
        mem_a[8'h12] = 8'sd3;    mem_b[8'h1A] = 8'sd7;
        mem_a[8'h13] = 8'sd4;    mem_b[8'h1B] = 8'sd8;
        mem_a[8'h40] = -8'sd128; mem_b[8'h48] = -8'sd128;
        mem_a[8'h41] = -8'sd128; mem_b[8'h49] = 8'sd127;
        mem_a[8'h42] = 8'sd127;  mem_b[8'h4A] = -8'sd128;
        mem_a[8'hFF] = 8'sd3;    mem_b[8'h60] = 8'sd5;
        mem_a[8'h00] = 8'sd4;    mem_b[8'h61] = 8'sd6;
        for (int i = 0; i < 4; i++) begin
            mem_a[8'h80 + i] = 8'sd127;
            mem_b[8'h90 + i] = 8'sd127;
        end

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        len    = '0;
        base_a = '0;
        base_b = '0;
        #1;
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-RUN of a len=8 job.
        start  = 1'b1;
        len    = LEN_W'(8);
        base_a = 8'hA0;
        base_b = 8'hB0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_addr_a", addr_a, 0);
        check("mid_rst_addr_b", addr_b, 0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_result", result, 0);
        check("mid_rst_sat", sat, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single element after reset.
        run_job(1, 8'h20, 8'h30, 6, 1'b0, 1'b0);
        tick();
        // Main case; the abort job below starts back-to-back in its done cycle.
        run_job(4, 8'h10, 8'h18, 70, 1'b0, 1'b0);

        // len=8 with abort in cycle 3.
        start  = 1'b1;
        len    = LEN_W'(8);
        base_a = 8'hA0;
        base_b = 8'hB0;
        tick();
        start = 1'b0;
        check("abort_c1_done", done, 1'b0);
        tick();
        tick();
        check("abort_c3_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_c4_busy", busy, 1'b0);
        check("abort_c4_rd_en", rd_en, 1'b0);
        for (int c = 4; c <= 12; c++) begin
            check($sformatf("abort_done_c%0d", c), done, 1'b0);
            check($sformatf("abort_busy_c%0d", c), busy, 1'b0);
            tick();
        end
        check("abort_result_kept", result, 70);

        // Extreme signed operands.
        run_job(3, 8'h40, 8'h48, -16128, 1'b0, 1'b0);
        tick();
        // len=0 with a second start held during busy.
        run_job(0, 8'h70, 8'h70, 0, 1'b0, 1'b1);
        tick();
        // Address wrap of vector A from 255 to 0.
        run_job(2, 8'hFF, 8'h60, 39, 1'b0, 1'b0);
        tick();
        // Large sum: saturated only with DOT_SAT_EN.
        run_job(4, 8'h80, 8'h90, BIG_RES, BIG_SAT, 1'b0);
        tick();
        check("final_done_low", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule : tb_dot_ctrl

// File: doc/dot_ctrl.md
# dot_ctrl

- Sequencer that computes a signed 8-bit dot product of two operand vectors held in synchronous-read memories.
- On a start request it generates read addresses and feeds the returned operand pairs into an internal instance of the team's signed 8×8→26-bit `mac`.
- It controls the MAC's clear, captures the final accumulator into a held result register, and signals completion with a one-cycle `done` pulse.
- It sits between the job-issuing control logic and the operand RAMs.

## Interface
Parameters:
- LEN_W, 7 — width of vector length; legal range 1..11, which guarantees no 26-bit accumulator overflow.
- ADDR_W, 8 — operand memory address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- len  in  LEN_W  number of element pairs; sampled with start.
- base_a  in  ADDR_W  start address of vector A; sampled with start.
- base_b  in  ADDR_W  start address of vector B; sampled with start.
- rd_en  out  1  read strobe to both memories.
- addr_a  out  ADDR_W  vector A read address.
- addr_b  out  ADDR_W  vector B read address.
- rdata_a  in  8  signed A data, valid the cycle after rd_en.
- rdata_b  in  8  signed B data, valid the cycle after rd_en.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- result  out  26  signed dot product; held until the next capture.
- sat  out  1  result was saturated (see Configuration).

## Operation
**FSM states:** IDLE, CLR, RUN, DRAIN, CAPT.
- IDLE: start=1 latches len, base_a, base_b → CLR. start is ignored in every other state.
- CLR: drives MAC clr_n=0.
  - len≠0: issues read index 0; → RUN if len>1, else → DRAIN.
  - len=0: → CAPT; no reads are issued.
- RUN: issues read index idx = 1..len−1; after index len−1 → DRAIN.
- DRAIN: no read issued; the last data word is accumulated → CAPT.
- CAPT: result ← MAC acc (after optional saturation); done ← 1 (registered); → IDLE.

**Datapath rules:**
- Addresses: addr_a = base_a + idx, addr_b = base_b + idx, modulo 2^ADDR_W (wraps silently).
- data_vld = rd_en delayed one cycle.
- MAC operands are rdata_a/rdata_b when data_vld=1, else 0. The MAC accumulates every cycle, so the operand gating is mandatory.
- busy = 1 in CLR, RUN, DRAIN and CAPT.

**abort:**
- abort=1 while busy → IDLE at the next edge.
- Clears rd_en and data_vld.
- No done pulse; result and sat unchanged.
- abort in IDLE has no effect.

**Reset:** asynchronous; valid at any point including mid-job. All outputs go to 0 (rd_en, addr_a, addr_b, busy, done, result, sat), the FSM returns to IDLE, and the MAC acc is cleared.

## Timing
Cycle 0 is the cycle in which start is sampled.
- Cycle 1 (CLR): read index 0 issued; acc = 0 after the edge.
- Cycle k+1, 0≤k<len: read index k issued; data k valid and accumulated in cycle k+2.
- Cycle len+1: DRAIN.
- Cycle len+2: CAPT.
- Cycle len+3: done=1 and result valid; busy=0.
- busy is high in cycles 1..len+2.
- A new start is accepted in the done cycle, which is back-to-back throughput.
- Memory read latency is fixed at 1 cycle.

## Configuration
Macro DOT_SAT_EN.
- Defined: at CAPT, the accumulator is clamped to the signed 16-bit range [−32768, 32767] and sign-extended into result. sat=1 if clamping occurred, else 0; sat is updated with result.
- Undefined: result is the full 26-bit accumulator and sat is tied 0.

## Structure
- Shared package mac_pkg holds:
  - state enum type dot_state_t;
  - ACC_W=26 and OP_W=8;
  - SAT_MAX and SAT_MIN constants.
- One sub-module: an instance of the existing `mac`, driven with gated a/b and clr_n from the FSM.
- Everything else (FSM, index counter, valid pipe, capture register) is local to dot_ctrl.

## Test plan
- Reset asserted mid-RUN of a len=8 job → all outputs 0 immediately; after release, start with len=1, A={2}, B={3} → result=6 in cycle 4.
- len=4, A={1,2,3,4}, B={5,6,7,8} → result=70, done only in cycle 7, busy cycles 1..6, addresses base..base+3.
- len=3, A={−128,−128,127}, B={−128,127,−128} → result=−16128.
- len=0 → no rd_en, done in cycle 3, result=0; a second start asserted during busy is ignored.
- Vector A at base_a=ADDR_W max, len=2 → addr_a reads 255 then 0.
- len=8 with abort in cycle 3 → busy low cycle 4, no done, result keeps prior 70.
- len=4 with all elements 127×127:
  - with DOT_SAT_EN → result=32767, sat=1;
  - without → result=64516, sat=0.
